// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, field positions, exception codes and FSM encoding
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} cp0_state_e;

  function automatic logic [31:0] status_word(logic [7:0] im, logic exl, logic ie);
    return {16'h0000, im, 6'b000000, exl, ie};
  endfunction

  function automatic logic [31:0] cause_word(logic [7:0] ip, logic [4:0] code);
    return {16'h0000, ip, 1'b0, code, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - pipeline-facing signal bundle of the CP0 exception controller
interface cp0_exc_ctrl_if;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_data;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        eret;
  logic [4:0]  hw_int;
  logic        exc_flush;
  logic [31:0] exc_target;
  logic [31:0] status_o;
  logic [31:0] epc_o;

  modport master (
    output mfc0_addr, mtc0_we, mtc0_addr, mtc0_data, exc_req, exc_code, exc_pc, eret, hw_int,
    input  mfc0_data, exc_flush, exc_target, status_o, epc_o
  );

  modport slave (
    input  mfc0_addr, mtc0_we, mtc0_addr, mtc0_data, exc_req, exc_code, exc_pc, eret, hw_int,
    output mfc0_data, exc_flush, exc_target, status_o, epc_o
  );
endinterface

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare pair with the sticky timer interrupt bit (Cause.IP[15])
module cp0_timer #(
  parameter logic [31:0] COUNT_RST   = 32'h0000_0000,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_ip
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= COUNT_RST;
      compare  <= COMPARE_RST;
      timer_ip <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + 32'd1;
      // a Compare write acknowledges the timer even if it coincides with a hit
      if (compare_we) begin
        compare  <= wdata;
        timer_ip <= 1'b0;
      end else if (count == compare) begin
        timer_ip <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 Status/Cause/EPC, MFC0/MTC0, exception/interrupt entry and ERET
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0008,
  parameter logic [31:0] COUNT_RST   = 32'h0000_0000,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input logic            clk,
  input logic            rst,
  cp0_exc_ctrl_if.slave  bus
);

  cp0_state_e  state, state_nxt;
  logic [7:0]  im;
  logic        exl, ie;
  logic [1:0]  ip_sw;
  logic [4:0]  ip_hw;
  logic [4:0]  exc_code_q;
  logic [31:0] epc;
  logic [31:0] count, compare;
  logic        timer_ip;
  logic [7:0]  ip;
  logic        int_pend;
  logic        take_exc, take_int, take_eret, mtc0_apply;
  logic        flush_q;
  logic [31:0] target_q;

  assign ip       = {timer_ip, ip_hw, ip_sw};
  assign int_pend = |(ip & im) & ie & ~exl;

  always_comb begin
    state_nxt  = state;
    take_exc   = 1'b0;
    take_int   = 1'b0;
    take_eret  = 1'b0;
    mtc0_apply = 1'b0;
    case (state)
      RUN: begin
        if (bus.exc_req) begin
          take_exc  = 1'b1;
          state_nxt = FLUSH;
        end else if (int_pend) begin
          take_int  = 1'b1;
          state_nxt = FLUSH;
        end else if (bus.eret) begin
          take_eret = 1'b1;
          state_nxt = FLUSH;
        end else begin
          mtc0_apply = bus.mtc0_we;
        end
      end
      FLUSH:   state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  cp0_timer #(.COUNT_RST(COUNT_RST), .COMPARE_RST(COMPARE_RST)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (mtc0_apply && bus.mtc0_addr == CP0_COUNT),
    .compare_we (mtc0_apply && bus.mtc0_addr == CP0_COMPARE),
    .wdata      (bus.mtc0_data),
    .count      (count),
    .compare    (compare),
    .timer_ip   (timer_ip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      im         <= 8'h00;
      exl        <= 1'b0;
      ie         <= 1'b0;
      ip_sw      <= 2'b00;
      ip_hw      <= 5'b00000;
      exc_code_q <= 5'b00000;
      epc        <= 32'h0;
      flush_q    <= 1'b0;
      target_q   <= 32'h0;
    end else begin
      ip_hw   <= bus.hw_int;
      flush_q <= take_exc | take_int | take_eret;
      if (take_exc || take_int) begin
        epc        <= bus.exc_pc;
        exc_code_q <= take_exc ? bus.exc_code : EXC_INT;
        exl        <= 1'b1;
        target_q   <= EXC_VECTOR;
      end else if (take_eret) begin
        exl      <= 1'b0;
        target_q <= epc;
      end else if (mtc0_apply) begin
        case (bus.mtc0_addr)
          CP0_STATUS: begin
            im  <= bus.mtc0_data[ST_IM_LO +: 8];
            exl <= bus.mtc0_data[ST_EXL];
            ie  <= bus.mtc0_data[ST_IE];
          end
          CP0_CAUSE: ip_sw <= bus.mtc0_data[CA_IP_LO +: 2];
          CP0_EPC:   epc   <= bus.mtc0_data;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.mfc0_data = 32'h0;
    case (bus.mfc0_addr)
      CP0_COUNT:   bus.mfc0_data = count;
      CP0_COMPARE: bus.mfc0_data = compare;
      CP0_STATUS:  bus.mfc0_data = status_word(im, exl, ie);
      CP0_CAUSE:   bus.mfc0_data = cause_word(ip, exc_code_q);
      CP0_EPC:     bus.mfc0_data = epc;
      default:     bus.mfc0_data = 32'h0;
    endcase
  end

  assign bus.exc_flush  = flush_q;
  assign bus.exc_target = target_q;
  assign bus.status_o   = status_word(im, exl, ie);
  assign bus.epc_o      = epc;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - scoreboard bench for cp0_exc_ctrl with a register-array reference model
module tb_cp0_exc_ctrl;
  import cp0_pkg::*;

  localparam logic [31:0] EXC_VECTOR  = 32'h0000_0008;
  localparam logic [31:0] COUNT_RST   = 32'h0000_0000;
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cp0_exc_ctrl_if bus();

  cp0_exc_ctrl #(
    .EXC_VECTOR  (EXC_VECTOR),
    .COUNT_RST   (COUNT_RST),
    .COMPARE_RST (COMPARE_RST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [31:0] target;
  } flush_t;
  flush_t exp_q[$];

  logic [31:0] m_reg [0:31];
  bit m_flushing = 0;
  bit m_valid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC: return m_reg[a];
      default: return 32'h0;
    endcase
  endfunction

  task automatic push_flush(input logic [31:0] target);
    flush_t e;
    e.cyc = cyc + 1;
    e.target = target;
    exp_q.push_back(e);
  endtask

  task automatic model_edge(input bit r, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                            input bit ex, input logic [4:0] code, input logic [31:0] pc,
                            input bit er, input logic [4:0] hw);
    bit hit, pend, cmp_wr;
    if (r) begin
      foreach (m_reg[i]) m_reg[i] = 32'h0;
      m_reg[CP0_COUNT]   = COUNT_RST;
      m_reg[CP0_COMPARE] = COMPARE_RST;
      m_flushing = 0;
      m_valid = 1;
      return;
    end
    hit    = (m_reg[CP0_COUNT] == m_reg[CP0_COMPARE]);
    pend   = ((m_reg[CP0_CAUSE][15:8] & m_reg[CP0_STATUS][15:8]) != 8'h0)
             && m_reg[CP0_STATUS][0] && !m_reg[CP0_STATUS][1];
    cmp_wr = 0;
    m_reg[CP0_COUNT] = m_reg[CP0_COUNT] + 32'd1;
    if (m_flushing) begin
      m_flushing = 0;
    end else if (ex || pend) begin
      m_reg[CP0_EPC] = pc;
      m_reg[CP0_CAUSE][6:2] = ex ? code : 5'd0;
      m_reg[CP0_STATUS][1] = 1'b1;
      push_flush(EXC_VECTOR);
      m_flushing = 1;
    end else if (er) begin
      push_flush(m_reg[CP0_EPC]);
      m_reg[CP0_STATUS][1] = 1'b0;
      m_flushing = 1;
    end else if (we) begin
      case (wa)
        CP0_COUNT:   m_reg[CP0_COUNT] = wd;
        CP0_COMPARE: begin m_reg[CP0_COMPARE] = wd; cmp_wr = 1; end
        CP0_STATUS:  m_reg[CP0_STATUS] = wd & 32'h0000_FF03;
        CP0_CAUSE:   m_reg[CP0_CAUSE] = (m_reg[CP0_CAUSE] & ~32'h0000_0300) | (wd & 32'h0000_0300);
        CP0_EPC:     m_reg[CP0_EPC] = wd;
        default: ;
      endcase
    end
    m_reg[CP0_CAUSE][14:10] = hw;
    if (cmp_wr)   m_reg[CP0_CAUSE][15] = 1'b0;
    else if (hit) m_reg[CP0_CAUSE][15] = 1'b1;
  endtask

  // Monitor: pops one expected redirect for each flush the DUT presents.
  always @(negedge clk) begin : monitor
    flush_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check("exc_flush pulse", {31'b0, bus.exc_flush}, 32'd1);
      check("exc_target", bus.exc_target, e.target);
    end else if (m_valid) begin
      check("exc_flush idle", {31'b0, bus.exc_flush}, 32'd0);
    end
  end

  task automatic tick();
    #1;
    if (m_valid && !rst) begin
      check("mfc0_data", bus.mfc0_data, model_read(bus.mfc0_addr));
      check("status_o", bus.status_o, m_reg[CP0_STATUS]);
      check("epc_o", bus.epc_o, m_reg[CP0_EPC]);
    end
    model_edge(rst, bus.mtc0_we, bus.mtc0_addr, bus.mtc0_data, bus.exc_req, bus.exc_code,
               bus.exc_pc, bus.eret, bus.hw_int);
    @(negedge clk);
    rst = 1'b0;
    bus.mtc0_we = 1'b0;
    bus.exc_req = 1'b0;
    bus.eret = 1'b0;
  endtask

  task automatic peek(input logic [4:0] a, output logic [31:0] d);
    bus.mfc0_addr = a;
    #1;
    d = bus.mfc0_data;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.mtc0_we = 1'b1;
    bus.mtc0_addr = a;
    bus.mtc0_data = d;
  endtask

  initial begin
    logic [31:0] d;
    int r;
    bus.mfc0_addr = 5'd0; bus.mtc0_we = 1'b0; bus.mtc0_addr = 5'd0; bus.mtc0_data = 32'h0;
    bus.exc_req = 1'b0; bus.exc_code = 5'd0; bus.exc_pc = 32'h0; bus.eret = 1'b0; bus.hw_int = 5'd0;

    // reset state and Count start value
    @(negedge clk);
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    peek(CP0_STATUS, d);  check("reset status", d, 32'h0);
    peek(CP0_COMPARE, d); check("reset compare", d, 32'hFFFF_FFFF);
    peek(CP0_EPC, d);     check("reset epc", d, 32'h0);
    tick(); tick(); tick();
    peek(CP0_COUNT, d);   check("count after 3 cycles", d, 32'd3);

    // synchronous exception entry
    mtc0(CP0_STATUS, 32'h0000_FF01); tick();
    bus.exc_req = 1'b1; bus.exc_code = EXC_SYS; bus.exc_pc = 32'h0040_0100; tick();
    check("exc flush", {31'b0, bus.exc_flush}, 32'd1);
    check("exc target", bus.exc_target, 32'h8);
    peek(CP0_EPC, d);     check("exc epc", d, 32'h0040_0100);
    peek(CP0_CAUSE, d);   check("exc code", {27'b0, d[6:2]}, 32'd8);
    peek(CP0_STATUS, d);  check("exc status", d, 32'h0000_FF03);
    tick();
    check("flush drops", {31'b0, bus.exc_flush}, 32'd0);

    // ERET back to EPC
    bus.eret = 1'b1; tick();
    check("eret flush", {31'b0, bus.exc_flush}, 32'd1);
    check("eret target", bus.exc_target, 32'h0040_0100);
    peek(CP0_STATUS, d);  check("eret status", d, 32'h0000_FF01);
    tick();

    // hardware interrupt, then exc_req ignored in the flush cycle
    mtc0(CP0_STATUS, 32'h0000_0401); bus.hw_int = 5'b00001; bus.exc_pc = 32'h1000; tick();
    tick();
    check("int flush", {31'b0, bus.exc_flush}, 32'd1);
    peek(CP0_EPC, d);     check("int epc", d, 32'h1000);
    peek(CP0_CAUSE, d);   check("int code", {27'b0, d[6:2]}, 32'd0);
    bus.exc_req = 1'b1; bus.exc_code = EXC_OV; bus.exc_pc = 32'h2000; tick();
    peek(CP0_EPC, d);     check("flush-cycle exc ignored", d, 32'h1000);
    bus.hw_int = 5'd0;

    // timer compare
    mtc0(CP0_COUNT, 32'd10); tick();
    mtc0(CP0_COMPARE, 32'd14); tick();
    tick(); tick(); tick();
    peek(CP0_CAUSE, d);   check("timer not yet", {31'b0, d[15]}, 32'd0);
    tick();
    peek(CP0_CAUSE, d);   check("timer hit", {31'b0, d[15]}, 32'd1);
    mtc0(CP0_COMPARE, 32'd100); tick();
    peek(CP0_CAUSE, d);   check("timer cleared", {31'b0, d[15]}, 32'd0);

    // MTC0 dropped under an exception, reset inside the flush cycle
    bus.exc_req = 1'b1; bus.exc_code = EXC_RI; bus.exc_pc = 32'h3000; mtc0(CP0_EPC, 32'hDEAD); tick();
    peek(CP0_EPC, d);     check("mtc0 dropped", d, 32'h3000);
    rst = 1'b1; tick();
    check("reset kills flush", {31'b0, bus.exc_flush}, 32'd0);
    check("reset target", bus.exc_target, 32'h0);
    peek(CP0_STATUS, d);  check("reset2 status", d, 32'h0);
    peek(CP0_EPC, d);     check("reset2 epc", d, 32'h0);
    peek(CP0_CAUSE, d);   check("reset2 cause", d, 32'h0);
    peek(CP0_COUNT, d);   check("reset2 count", d, COUNT_RST);
    peek(CP0_COMPARE, d); check("reset2 compare", d, COMPARE_RST);

    // randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(99);
      bus.mfc0_addr = 5'($urandom_range(15));
      bus.exc_pc    = $urandom & 32'hFFFF_FFFC;
      bus.exc_code  = 5'($urandom);
      if ($urandom_range(7) == 0) bus.hw_int = 5'($urandom);
      if (r < 8) bus.exc_req = 1'b1;
      else if (r < 16) bus.eret = 1'b1;
      if ($urandom_range(2) == 0) begin
        case ($urandom_range(6))
          0: mtc0(CP0_COUNT, $urandom_range(1) ? $urandom : m_reg[CP0_COMPARE] - 32'($urandom_range(4)));
          1: mtc0(CP0_COMPARE, m_reg[CP0_COUNT] + 32'($urandom_range(6)));
          2: mtc0(CP0_STATUS, $urandom);
          3: mtc0(CP0_CAUSE, $urandom);
          4: mtc0(CP0_EPC, $urandom);
          default: mtc0(5'($urandom), $urandom);
        endcase
      end
      if ($urandom_range(299) == 0) rst = 1'b1;
      tick();
    end

    bus.hw_int = 5'd0;
    tick(); tick();
    check("flush queue drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Coprocessor-0 control block on the read and consume side of the CP0 registers.
- Holds Count, Compare, Status, Cause and EPC.
- Serves MFC0 reads and MTC0 writes.
- Detects exceptions and interrupts, steers the pipeline via a one-cycle flush with a redirect target, and handles ERET.
- Sits beside the MEM stage; the PC mux consumes its flush/target outputs.

Parameters:
EXC_VECTOR, 32'h0000_0008, redirect address on exception or interrupt entry
COUNT_RST, 32'h0000_0000, Count reset value
COMPARE_RST, 32'hFFFF_FFFF, Compare reset value (prevents a timer hit at reset)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
mfc0_addr  in  5  CP0 register number to read
mfc0_data  out  32  read data, combinational
mtc0_we  in  1  write strobe
mtc0_addr  in  5  CP0 register number to write
mtc0_data  in  32  write data
exc_req  in  1  synchronous exception from pipeline
exc_code  in  5  ExcCode for exc_req
exc_pc  in  32  PC of the faulting or interrupted instruction
eret  in  1  ERET retiring this cycle
hw_int  in  5  external interrupt lines -> Cause.IP[6:2], level-sensitive
exc_flush  out  1  registered one-cycle flush pulse
exc_target  out  32  registered redirect PC, valid while exc_flush=1
status_o  out  32  current Status
epc_o  out  32  current EPC

Behaviour:
Register map and write rules:
- 9=Count, 11=Compare, 12=Status, 13=Cause, 14=EPC.
- Other addresses read 0; writes to them are ignored.
- Status: writable bits are IM[15:8], EXL[1], IE[0]; all others read 0.
- Cause: IP[9:8] writable (software interrupts). IP[15:10] are hardware-set. ExcCode is [6:2]. Other bits read 0.

Reset (rst=1 at posedge):
- Status=0, Cause=0, EPC=0, Count=COUNT_RST, Compare=COMPARE_RST.
- exc_flush=0, exc_target=0, state=RUN.

Count and timer:
- Count increments by 1 every cycle and wraps 32'hFFFF_FFFF->0.
- An MTC0 to Count loads mtc0_data instead of incrementing.
- When Count==Compare at a clock edge, Cause.IP[15] is set on that edge.
- An MTC0 to Compare clears IP[15].
- IP[14:10] <= hw_int every cycle.

Interrupt condition:
- int_pend = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL.

State machine (states RUN, FLUSH):
- RUN, priority exc_req > int_pend > eret > mtc0_we. Exactly one event is taken per cycle:
  - exc_req: EPC<=exc_pc, ExcCode<=exc_code, EXL<=1, exc_flush<=1, exc_target<=EXC_VECTOR, go FLUSH.
  - int_pend: EPC<=exc_pc, ExcCode<=0, EXL<=1, exc_flush<=1, exc_target<=EXC_VECTOR, go FLUSH.
  - eret: EXL<=0, exc_flush<=1, exc_target<=EPC (pre-edge value), go FLUSH.
  - otherwise: an MTC0, if present, is applied.
- If an exception, interrupt or ERET is taken in the same cycle as mtc0_we, the MTC0 is dropped.
- FLUSH: exc_flush<=0. exc_req, eret and mtc0_we are ignored, since the pipeline is flushing. Return to RUN next cycle.
- Count, IP hardware bits and timer logic run in both states.

Read port and latency:
- mfc0_data is purely combinational on current register state.
- There is no write-to-read bypass: a same-cycle MTC0 is visible on the next cycle.
- Latency: event at edge N -> exc_flush high during cycle N+1 -> low at N+2.

Other rules:
- A mid-operation reset drops any pending flush immediately.
- hw_int lines are assumed synchronized upstream.

Decomposition:
- Shared package cp0_pkg: CP0 register numbers (CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14), Status/Cause bit positions, ExcCode constants (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12), state encoding.
- Natural sub-module: cp0_timer (Count/Compare plus timer IP output, with load/clear inputs).

Test Plan:
1. Reset, then mfc0_addr=12 -> mfc0_data=0. mfc0_addr=11 -> 32'hFFFF_FFFF. Count reads 3 three cycles after reset release.
2. MTC0 Status=32'h0000_FF01, then exc_req with exc_code=8 and exc_pc=32'h0040_0100 -> next cycle exc_flush=1, exc_target=32'h8. EPC=32'h0040_0100, Cause[6:2]=8, Status=32'h0000_FF03. exc_flush=0 the following cycle.
3. From test 2, eret -> exc_flush=1, exc_target=32'h0040_0100, Status.EXL=0.
4. Status=32'h0000_0401, hw_int=5'b00001, exc_pc=32'h1000 -> interrupt taken, ExcCode=0, EPC=32'h1000. A second exc_req in the FLUSH cycle is ignored (EPC unchanged).
5. MTC0 Count=10, Compare=14 -> Cause.IP[15]=1 after Count reaches 14. MTC0 Compare=100 -> IP[15]=0.
6. Same-cycle exc_req and mtc0_we (addr 14, data 32'hDEAD) -> EPC=exc_pc, not 32'hDEAD. rst asserted in the FLUSH cycle -> exc_flush=0 and all registers return to reset values.
